cce_dir_segment: RTL and testbench
==================================

// Module: cce_dir_segment
// PURPOSE
//  Coherence directory slice for one LCE class (I$, D$ or A$) inside the CCE directory.
//  Holds a {tag, coh_state} entry per (tag set, LCE, way).
//  Services four operations:
//   - way-group read: builds the sharer vectors and the LRU victim info.
//   - entry read: reconstructs the block address of one entry.
//   - entry write; state-only write.
//  Parent ORs/ANDs the outputs of all segments.
// PARAMETERS
//  tag_sets_p            64  sets tracked by this CCE (CDIV(sets_p,num_cce_p))
//  num_lce_p             2   LCEs of this class
//  sets_p                64  sets per LCE cache (power of 2)
//  assoc_p               8   ways per LCE cache
//  paddr_width_p         40  physical address width
//  num_cce_p             1   number of CCEs (power of 2)
//  block_size_in_bytes_p 64  cache block size
// PORTS
//  clk_i                 in  1    clock
//  reset_i               in  1    reset: asynchronous, active-high
//  addr_i                in  paddr_width_p  request address
//  addr_bypass_i         in  1    e_rde_op: return addr_i instead of reading the array
//  lce_i                 in  SAFE_CLOG2(num_lce_p)  LCE index within segment
//  way_i                 in  SAFE_CLOG2(assoc_p)    way for rde/wde/wds
//  lru_way_i             in  SAFE_CLOG2(assoc_p)    LRU way of lce_i for rdw
//  coh_state_i           in  bp_coh_states_e        state to write
//  addr_dst_gpr_i        in  bp_cce_inst_opd_gpr_e  destination GPR tag (echoed)
//  cmd_i                 in  bp_cce_inst_minor_dir_op_e  e_rdw_op/e_rde_op/e_wde_op/e_wds_op/e_clr_op
//  r_v_i                 in  1    read command valid
//  r_lru_v_i             in  1    capture LRU info during rdw
//  w_v_i                 in  1    write command valid
//  busy_o                out 1    rdw in progress; no command accepted
//  sharers_v_o           out 1    sharer vectors valid
//  sharers_hits_o        out num_lce_p  per-LCE hit
//  sharers_ways_o        out num_lce_p x SAFE_CLOG2(assoc_p)  hit way
//  sharers_coh_states_o  out num_lce_p x bp_coh_states_e      hit state
//  lru_v_o, lru_coh_state_o, lru_addr_o   out  1/state/paddr  LRU entry info
//  addr_v_o, addr_o, addr_dst_gpr_o       out  1/paddr/gpr    rde result
// BEHAVIOUR
//  - Address fields:
//    - lgB = log2(block bytes); set = addr[lgB +: log2(sets_p)].
//    - Tag set = addr[lgB+log2(num_cce_p) +: log2(tag_sets_p)].
//    - Tag = addr[paddr_width_p-1 : lgB+log2(sets_p)].
//    - Reconstructed address = {stored tag, set of latched addr_i, lgB zeros}.
//  - Storage in flops.
//  - Reset (async) clears:
//    - every entry to tag 0, e_COH_I;
//    - all outputs to 0, state outputs e_COH_I, gpr e_opd_r0.
//  - Commands are accepted only when busy_o=0. r_v_i and w_v_i are never both high.
//  - Writes commit at the accepting edge:
//    - wde sets {tag,state} at (tag set, lce_i, way_i);
//    - wds sets state only;
//    - clr invalidates all entries of the tag set.
//  - Writes do not change the sharer outputs.
//  - e_rdw_op:
//    - Accept clears sharers_v_o, latches addr/lce/lru_way/r_lru_v.
//    - FSM IDLE->RDW scans one LCE per cycle (index 0..num_lce_p-1); busy_o=1 for exactly num_lce_p cycles, then back to IDLE.
//    - On leaving RDW, sharers_v_o=1 and stays 1 until the next rdw accept or reset.
//    - Hit = tag match and state != e_COH_I; the lowest hitting way is reported.
//    - A miss reports way 0 and e_COH_I.
//    - If r_lru_v_i was set, lru_v_o pulses 1 cycle together with sharers_v_o rising.
//    - lru_coh_state_o and lru_addr_o give the entry (latched lce, lru_way) and hold until the next rdw.
//  - e_rde_op:
//    - Single cycle, busy_o stays 0.
//    - addr_v_o pulses the cycle after accept.
//    - addr_o = reconstructed address of (lce_i, way_i), or addr_i with the offset cleared when addr_bypass_i=1.
//    - addr_dst_gpr_o = latched addr_dst_gpr_i.
//  - Commands issued while busy, or unknown cmd, are ignored.
//  - Reset mid-rdw aborts immediately: busy_o=0, sharers_v_o=0.
// TESTING
//  - Reset; rdw addr 0x80000040 -> busy 2 cycles, then sharers_v=1, hits=00, states I.
//  - wde lce1 way3 e_COH_S addr 0x80001040; rdw same -> hits=10, ways[1]=3, states[1]=S.
//  - rde lce1 way3 addr 0x00000040 gpr r5 -> next cycle addr_v=1, addr_o=0x80001040, gpr r5; bypass=1 with addr 0x12345678 -> addr_o=0x12345640.
//  - rdw r_lru_v=1 lce1 lru_way3 -> lru_v single pulse, lru_addr=0x80001040, state S.
//  - wds lce1 way3 e_COH_I, then rdw -> hits=00; wde again, clr, rdw -> hits=00.
//  - Assert reset during rdw -> busy_o and sharers_v_o 0 asynchronously; a command sent while busy leaves the array unchanged.

Source files
------------

// File: rtl/cce_dir_segment.sv
// Coherence directory slice for one LCE class: {tag, coh_state} per (tag set, LCE, way).
// Latency: rdw results after num_lce_p cycles (one LCE per cycle); rde result 1 cycle; writes commit at accept.
// Backpressure: busy_o high during an rdw scan; commands presented while busy are dropped, not stalled.
//
// Ports:
//   clk_i, reset_i                  clock, async active-high reset
//   addr_i, addr_bypass_i           request address; rde returns addr_i (offset cleared) when bypass set
//   lce_i, way_i, lru_way_i         entry selectors
//   coh_state_i, addr_dst_gpr_i     write state; destination GPR tag echoed with the rde result
//   cmd_i, r_v_i, r_lru_v_i, w_v_i  command, read/write valids, LRU capture request
//   busy_o                          rdw in progress
//   sharers_*_o                     per-LCE hit / way / state from the last rdw
//   lru_*_o                         entry (latched lce, lru_way) from the last rdw
//   addr_v_o, addr_o, addr_dst_gpr_o  rde result
package cce_dir_pkg;
  typedef enum logic [2:0] {
    e_COH_I = 3'd0, e_COH_S = 3'd1, e_COH_E = 3'd2, e_COH_F = 3'd3,
    e_COH_M = 3'd4, e_COH_O = 3'd5
  } bp_coh_states_e;

  typedef enum logic [3:0] {
    e_opd_r0 = 4'd0, e_opd_r1 = 4'd1, e_opd_r2 = 4'd2, e_opd_r3 = 4'd3,
    e_opd_r4 = 4'd4, e_opd_r5 = 4'd5, e_opd_r6 = 4'd6, e_opd_r7 = 4'd7
  } bp_cce_inst_opd_gpr_e;

  typedef enum logic [3:0] {
    e_rdw_op = 4'd0, e_rde_op = 4'd1, e_wde_op = 4'd2, e_wds_op = 4'd3, e_clr_op = 4'd4
  } bp_cce_inst_minor_dir_op_e;
endpackage

module cce_dir_segment
  import cce_dir_pkg::*;
#(
  parameter int tag_sets_p            = 64,
  parameter int num_lce_p             = 2,
  parameter int sets_p                = 64,
  parameter int assoc_p               = 8,
  parameter int paddr_width_p         = 40,
  parameter int num_cce_p             = 1,
  parameter int block_size_in_bytes_p = 64,
  localparam int lce_w_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int way_w_lp = (assoc_p > 1) ? $clog2(assoc_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [paddr_width_p-1:0]               addr_i,
  input  logic                                   addr_bypass_i,
  input  logic [lce_w_lp-1:0]                    lce_i,
  input  logic [way_w_lp-1:0]                    way_i,
  input  logic [way_w_lp-1:0]                    lru_way_i,
  input  bp_coh_states_e                         coh_state_i,
  input  bp_cce_inst_opd_gpr_e                   addr_dst_gpr_i,
  input  bp_cce_inst_minor_dir_op_e              cmd_i,
  input  logic                                   r_v_i,
  input  logic                                   r_lru_v_i,
  input  logic                                   w_v_i,
  output logic                                   busy_o,
  output logic                                   sharers_v_o,
  output logic [num_lce_p-1:0]                   sharers_hits_o,
  output logic [num_lce_p-1:0][way_w_lp-1:0]     sharers_ways_o,
  output bp_coh_states_e [num_lce_p-1:0]         sharers_coh_states_o,
  output logic                                   lru_v_o,
  output bp_coh_states_e                         lru_coh_state_o,
  output logic [paddr_width_p-1:0]               lru_addr_o,
  output logic                                   addr_v_o,
  output logic [paddr_width_p-1:0]               addr_o,
  output bp_cce_inst_opd_gpr_e                   addr_dst_gpr_o
);

  localparam int lg_block_lp    = $clog2(block_size_in_bytes_p);
  localparam int lg_sets_lp     = $clog2(sets_p);
  localparam int lg_cce_lp      = $clog2(num_cce_p);
  localparam int lg_tag_sets_lp = $clog2(tag_sets_p);
  localparam int line_w_lp      = paddr_width_p - lg_block_lp;
  localparam int tag_w_lp       = paddr_width_p - lg_block_lp - lg_sets_lp;
  localparam logic [paddr_width_p-1:0] off_mask_lp =
    {{line_w_lp{1'b0}}, {lg_block_lp{1'b1}}};

  typedef enum logic {e_idle, e_rdw} fsm_e;

  // Directory storage
  logic [tag_w_lp-1:0] tag_r [tag_sets_p][num_lce_p][assoc_p];
  bp_coh_states_e      st_r  [tag_sets_p][num_lce_p][assoc_p];

  fsm_e state_r, state_n;

  // Latched rdw context
  logic [line_w_lp-1:0] addr_r;
  logic [lce_w_lp-1:0]  lce_r;
  logic [way_w_lp-1:0]  lru_way_r;
  logic                 lru_req_r;
  logic [lce_w_lp-1:0]  cnt_r;

  // Request address fields
  logic [lg_tag_sets_lp-1:0] req_tset;
  logic [lg_sets_lp-1:0]     req_set;
  logic [tag_w_lp-1:0]       req_tag;

  // Scan address fields (from the latched block address)
  logic [lg_tag_sets_lp-1:0] scan_tset;
  logic [lg_sets_lp-1:0]     scan_set;
  logic [tag_w_lp-1:0]       scan_tag;

  logic                 scan_hit;
  logic [way_w_lp-1:0]  scan_way;
  bp_coh_states_e       scan_state;

  logic rdw_accept, rde_accept, wr_en, scan_last;

  assign req_tset  = addr_i[lg_block_lp+lg_cce_lp +: lg_tag_sets_lp];
  assign req_set   = addr_i[lg_block_lp +: lg_sets_lp];
  assign req_tag   = addr_i[paddr_width_p-1 -: tag_w_lp];

  assign scan_tset = addr_r[lg_cce_lp +: lg_tag_sets_lp];
  assign scan_set  = addr_r[0 +: lg_sets_lp];
  assign scan_tag  = addr_r[line_w_lp-1 -: tag_w_lp];

  assign busy_o = (state_r == e_rdw);

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // FSM next state and command decode
  always_comb begin
    state_n    = state_r;
    rdw_accept = 1'b0;
    rde_accept = 1'b0;
    wr_en      = 1'b0;
    scan_last  = 1'b0;
    case (state_r)
      e_idle: begin
        rdw_accept = r_v_i && (cmd_i == e_rdw_op);
        rde_accept = r_v_i && (cmd_i == e_rde_op);
        wr_en      = w_v_i;
        if (rdw_accept) state_n = e_rdw;
      end
      e_rdw: begin
        if (cnt_r == lce_w_lp'(num_lce_p-1)) begin
          scan_last = 1'b1;
          state_n   = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Way search for the LCE being scanned; descending order so the lowest hit wins
  always_comb begin
    scan_hit   = 1'b0;
    scan_way   = '0;
    scan_state = e_COH_I;
    for (int w = assoc_p-1; w >= 0; w--) begin
      if ((tag_r[scan_tset][cnt_r][w] == scan_tag) && (st_r[scan_tset][cnt_r][w] != e_COH_I)) begin
        scan_hit   = 1'b1;
        scan_way   = way_w_lp'(w);
        scan_state = st_r[scan_tset][cnt_r][w];
      end
    end
  end

  // Directory array writes
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < tag_sets_p; s++)
        for (int l = 0; l < num_lce_p; l++)
          for (int w = 0; w < assoc_p; w++) begin
            tag_r[s][l][w] <= '0;
            st_r[s][l][w]  <= e_COH_I;
          end
    end else if (wr_en) begin
      case (cmd_i)
        e_wde_op: begin
          tag_r[req_tset][lce_i][way_i] <= req_tag;
          st_r[req_tset][lce_i][way_i]  <= coh_state_i;
        end
        e_wds_op: st_r[req_tset][lce_i][way_i] <= coh_state_i;
        e_clr_op: begin
          for (int l = 0; l < num_lce_p; l++)
            for (int w = 0; w < assoc_p; w++)
              st_r[req_tset][l][w] <= e_COH_I;
        end
        default: ;
      endcase
    end
  end

  // Read datapath and outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_r          <= '0;
      lce_r           <= '0;
      lru_way_r       <= '0;
      lru_req_r       <= 1'b0;
      cnt_r           <= '0;
      sharers_v_o     <= 1'b0;
      sharers_hits_o  <= '0;
      sharers_ways_o  <= '0;
      for (int l = 0; l < num_lce_p; l++) sharers_coh_states_o[l] <= e_COH_I;
      lru_v_o         <= 1'b0;
      lru_coh_state_o <= e_COH_I;
      lru_addr_o      <= '0;
      addr_v_o        <= 1'b0;
      addr_o          <= '0;
      addr_dst_gpr_o  <= e_opd_r0;
    end else begin
      lru_v_o  <= 1'b0;
      addr_v_o <= rde_accept;

      if (rdw_accept) begin
        sharers_v_o <= 1'b0;
        addr_r      <= addr_i[paddr_width_p-1:lg_block_lp];
        lce_r       <= lce_i;
        lru_way_r   <= lru_way_i;
        lru_req_r   <= r_lru_v_i;
        cnt_r       <= '0;
      end

      if (state_r == e_rdw) begin
        sharers_hits_o[cnt_r]       <= scan_hit;
        sharers_ways_o[cnt_r]       <= scan_way;
        sharers_coh_states_o[cnt_r] <= scan_state;
        cnt_r                       <= cnt_r + lce_w_lp'(1);
        if (scan_last) begin
          sharers_v_o     <= 1'b1;
          lru_v_o         <= lru_req_r;
          lru_coh_state_o <= st_r[scan_tset][lce_r][lru_way_r];
          lru_addr_o      <= {tag_r[scan_tset][lce_r][lru_way_r], scan_set, {lg_block_lp{1'b0}}};
        end
      end

      if (rde_accept) begin
        addr_dst_gpr_o <= addr_dst_gpr_i;
        if (addr_bypass_i) addr_o <= addr_i & ~off_mask_lp;
        else               addr_o <= {tag_r[req_tset][lce_i][way_i], req_set, {lg_block_lp{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_cce_dir_segment.sv
module tb_cce_dir_segment;
  import cce_dir_pkg::*;

  localparam int NSETS = 64;
  localparam int NLCE  = 2;
  localparam int NWAY  = 8;
  localparam int PA    = 40;
  localparam int LGB   = 6;
  localparam int LGS   = 6;
  localparam int LCEW  = 1;
  localparam int WAYW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [PA-1:0]  addr = '0;
  logic           bypass = 1'b0;
  logic [LCEW-1:0] lce = '0;
  logic [WAYW-1:0] way = '0;
  logic [WAYW-1:0] lru_way = '0;
  bp_coh_states_e  cstate = e_COH_I;
  bp_cce_inst_opd_gpr_e gpr = e_opd_r0;
  bp_cce_inst_minor_dir_op_e cmd = e_rdw_op;
  logic r_v = 1'b0, r_lru_v = 1'b0, w_v = 1'b0;

  logic                       busy, sv, lru_v, addr_v;
  logic [NLCE-1:0]            hits;
  logic [NLCE-1:0][WAYW-1:0]  ways;
  bp_coh_states_e [NLCE-1:0]  states;
  bp_coh_states_e             lru_st;
  logic [PA-1:0]              lru_addr, addr_out;
  bp_cce_inst_opd_gpr_e       gpr_out;

  cce_dir_segment #(
    .tag_sets_p(NSETS), .num_lce_p(NLCE), .sets_p(NSETS), .assoc_p(NWAY),
    .paddr_width_p(PA), .num_cce_p(1), .block_size_in_bytes_p(64)
  ) dut (
    .clk_i(clk), .reset_i(rst), .addr_i(addr), .addr_bypass_i(bypass),
    .lce_i(lce), .way_i(way), .lru_way_i(lru_way), .coh_state_i(cstate),
    .addr_dst_gpr_i(gpr), .cmd_i(cmd), .r_v_i(r_v), .r_lru_v_i(r_lru_v), .w_v_i(w_v),
    .busy_o(busy), .sharers_v_o(sv), .sharers_hits_o(hits), .sharers_ways_o(ways),
    .sharers_coh_states_o(states), .lru_v_o(lru_v), .lru_coh_state_o(lru_st),
    .lru_addr_o(lru_addr), .addr_v_o(addr_v), .addr_o(addr_out), .addr_dst_gpr_o(gpr_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PA-1:0] m_tag [NSETS][NLCE][NWAY];
  int            m_st  [NSETS][NLCE][NWAY];

  int            busy_left;
  bit            sh_known;
  bit            e_sv, e_lru_v, e_addr_v;
  bit            e_hits [NLCE];
  int            e_ways [NLCE];
  int            e_states [NLCE];
  int            e_lru_st, e_gpr;
  logic [PA-1:0] e_lru_addr, e_addr;
  bit            p_hits [NLCE];
  int            p_ways [NLCE];
  int            p_states [NLCE];
  bit            p_lru_req;
  int            p_lru_st;
  logic [PA-1:0] p_lru_addr;
  bit            m_acc;
  int            ts, st_idx;
  logic [PA-1:0] tg;

  function automatic int set_of(input logic [PA-1:0] a);
    return int'((a >> LGB) % NSETS);
  endfunction
  function automatic logic [PA-1:0] tag_of(input logic [PA-1:0] a);
    return a >> (LGB + LGS);
  endfunction
  function automatic logic [PA-1:0] rebuild(input logic [PA-1:0] t, input int s);
    return (t << (LGB + LGS)) | (PA'(s) << LGB);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++)
        for (int l = 0; l < NLCE; l++)
          for (int w = 0; w < NWAY; w++) begin
            m_tag[s][l][w] = '0;
            m_st[s][l][w]  = 0;
          end
      busy_left = 0; sh_known = 1; e_sv = 0; e_lru_v = 0; e_addr_v = 0;
      for (int l = 0; l < NLCE; l++) begin e_hits[l] = 0; e_ways[l] = 0; e_states[l] = 0; end
      e_lru_st = 0; e_lru_addr = '0; e_addr = '0; e_gpr = 0;
    end else begin
      m_acc   = (busy_left == 0);
      e_lru_v = 0;
      e_addr_v = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          e_sv = 1; sh_known = 1;
          for (int l = 0; l < NLCE; l++) begin
            e_hits[l] = p_hits[l]; e_ways[l] = p_ways[l]; e_states[l] = p_states[l];
          end
          e_lru_v = p_lru_req; e_lru_st = p_lru_st; e_lru_addr = p_lru_addr;
        end
      end
      if (m_acc) begin
        ts = set_of(addr);  // single CCE: tag set coincides with cache set
        tg = tag_of(addr);
        if (r_v && cmd == e_rdw_op) begin
          for (int l = 0; l < NLCE; l++) begin
            p_hits[l] = 0; p_ways[l] = 0; p_states[l] = 0;
            for (int w = 0; w < NWAY; w++)
              if (!p_hits[l] && m_tag[ts][l][w] == tg && m_st[ts][l][w] != 0) begin
                p_hits[l] = 1; p_ways[l] = w; p_states[l] = m_st[ts][l][w];
              end
          end
          p_lru_req  = r_lru_v;
          p_lru_st   = m_st[ts][lce][lru_way];
          p_lru_addr = rebuild(m_tag[ts][lce][lru_way], ts);
          e_sv = 0; sh_known = 0; busy_left = NLCE;
        end else if (r_v && cmd == e_rde_op) begin
          e_addr_v = 1;
          e_gpr    = int'(gpr);
          e_addr   = bypass ? (addr & ~PA'(63)) : rebuild(m_tag[ts][lce][way], ts);
        end else if (w_v && cmd == e_wde_op) begin
          m_tag[ts][lce][way] = tg;
          m_st[ts][lce][way]  = int'(cstate);
        end else if (w_v && cmd == e_wds_op) begin
          m_st[ts][lce][way] = int'(cstate);
        end else if (w_v && cmd == e_clr_op) begin
          for (int l = 0; l < NLCE; l++)
            for (int w = 0; w < NWAY; w++) m_st[ts][l][w] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if ($time > 2) begin
      chk("busy", busy, busy_left > 0);
      chk("sharers_v", sv, e_sv);
      chk("lru_v", lru_v, e_lru_v);
      chk("addr_v", addr_v, e_addr_v);
      chk("lru_state", lru_st, e_lru_st);
      chk("lru_addr", lru_addr, e_lru_addr);
      chk("addr_o", addr_out, e_addr);
      chk("gpr", gpr_out, e_gpr);
      if (sh_known)
        for (int l = 0; l < NLCE; l++) begin
          chk($sformatf("hit[%0d]", l), hits[l], e_hits[l]);
          chk($sformatf("way[%0d]", l), ways[l], e_ways[l]);
          chk($sformatf("state[%0d]", l), states[l], e_states[l]);
        end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input bp_cce_inst_minor_dir_op_e c, input bit rv, input bit wv,
                    input logic [PA-1:0] a, input int l, input int w, input bp_coh_states_e s,
                    input int lw, input bit lv, input bit byp, input bp_cce_inst_opd_gpr_e g);
    cmd = c; r_v = rv; w_v = wv; addr = a; lce = LCEW'(l); way = WAYW'(w); cstate = s;
    lru_way = WAYW'(lw); r_lru_v = lv; bypass = byp; gpr = g;
    @(posedge clk); #1;
    r_v = 0; w_v = 0; r_lru_v = 0;
  endtask

  task automatic wde(input logic [PA-1:0] a, input int l, input int w, input bp_coh_states_e s);
    op(e_wde_op, 0, 1, a, l, w, s, 0, 0, 0, e_opd_r0);
  endtask
  task automatic rdw(input logic [PA-1:0] a, input int l, input int lw, input bit lv);
    op(e_rdw_op, 1, 0, a, l, 0, e_COH_I, lw, lv, 0, e_opd_r0);
    repeat (NLCE) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_sv", sv, 0);
    chk("rst_addr_v", addr_v, 0);
    chk("rst_gpr", gpr_out, 0);

    // empty directory
    op(e_rdw_op, 1, 0, 40'h80000040, 0, 0, e_COH_I, 0, 0, 0, e_opd_r0);
    chk("rdw0_busy_c1", busy, 1);
    chk("rdw0_sv_c1", sv, 0);
    @(posedge clk); #1;
    chk("rdw0_busy_c2", busy, 1);
    @(posedge clk); #1;
    chk("rdw0_busy_done", busy, 0);
    chk("rdw0_sv", sv, 1);
    chk("rdw0_hits", hits, 2'b00);
    chk("rdw0_states", {states[1], states[0]}, 6'd0);

    // single sharer
    wde(40'h80001040, 1, 3, e_COH_S);
    rdw(40'h80001040, 0, 0, 0);
    chk("rdw1_hits", hits, 2'b10);
    chk("rdw1_way1", ways[1], 3);
    chk("rdw1_state1", states[1], e_COH_S);

    // entry read and bypass
    op(e_rde_op, 1, 0, 40'h00000040, 1, 3, e_COH_I, 0, 0, 0, e_opd_r5);
    chk("rde_v", addr_v, 1);
    chk("rde_addr", addr_out, 40'h80001040);
    chk("rde_gpr", gpr_out, 5);
    @(posedge clk); #1;
    chk("rde_v_pulse", addr_v, 0);
    op(e_rde_op, 1, 0, 40'h12345678, 0, 0, e_COH_I, 0, 0, 1, e_opd_r2);
    chk("rde_byp_addr", addr_out, 40'h12345640);
    chk("rde_byp_gpr", gpr_out, 2);

    // LRU capture
    rdw(40'h80001040, 1, 3, 1);
    chk("lru_v", lru_v, 1);
    chk("lru_addr", lru_addr, 40'h80001040);
    chk("lru_state", lru_st, e_COH_S);
    @(posedge clk); #1;
    chk("lru_v_pulse", lru_v, 0);

    // lowest hitting way wins; different tag in same set does not hit
    wde(40'h90001040, 0, 1, e_COH_S);
    wde(40'h80001040, 0, 5, e_COH_M);
    wde(40'h80001040, 0, 2, e_COH_E);
    rdw(40'h80001040, 0, 0, 0);
    chk("multi_hits", hits, 2'b11);
    chk("multi_way0", ways[0], 2);
    chk("multi_state0", states[0], e_COH_E);

    // state-only write, then clear
    op(e_wds_op, 0, 1, 40'h80001040, 1, 3, e_COH_I, 0, 0, 0, e_opd_r0);
    rdw(40'h80001040, 0, 0, 0);
    chk("wds_hits", hits, 2'b01);
    wde(40'h80001040, 1, 3, e_COH_S);
    op(e_clr_op, 0, 1, 40'h80001040, 0, 0, e_COH_I, 0, 0, 0, e_opd_r0);
    rdw(40'h80001040, 0, 0, 0);
    chk("clr_hits", hits, 2'b00);

    // write while busy and unknown command are both dropped
    wde(40'h80001040, 1, 0, e_COH_M);
    op(e_rdw_op, 1, 0, 40'h80001040, 0, 0, e_COH_I, 0, 0, 0, e_opd_r0);
    op(e_wde_op, 0, 1, 40'h80001040, 0, 0, e_COH_S, 0, 0, 0, e_opd_r0);
    @(posedge clk); #1;
    op(bp_cce_inst_minor_dir_op_e'(4'hF), 0, 1, 40'h80001040, 0, 0, e_COH_S, 0, 0, 0, e_opd_r0);
    rdw(40'h80001040, 0, 0, 0);
    chk("busy_wr_hits", hits, 2'b10);
    chk("busy_wr_way1", ways[1], 0);
    chk("busy_wr_state1", states[1], e_COH_M);

    // reset mid-rdw aborts asynchronously and clears the array
    op(e_rdw_op, 1, 0, 40'h80001040, 0, 0, e_COH_I, 0, 0, 0, e_opd_r0);
    chk("abort_busy_pre", busy, 1);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sv", sv, 0);
    @(posedge clk); #1 rst = 0;
    rdw(40'h80001040, 0, 0, 0);
    chk("post_rst_hits", hits, 2'b00);

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
